// File: rtl/fib_pkg.sv
// -----------------------------------------------------------------------------
// fib_pkg
// Shared types and constants for the Fibonacci-family term generator.
//   fib_mode_e  : seed selection carried on req_mode (encoding 3 is reserved
//                 and behaves as FIB)
//   fib_state_e : control FSM states of fib_seq_gen
//   LUCAS_T0/1  : seeds t(0), t(1) of the Lucas sequence
// -----------------------------------------------------------------------------
package fib_pkg;

    typedef enum logic [1:0] {
        FIB    = 2'd0,
        LUCAS  = 2'd1,
        CUSTOM = 2'd2
    } fib_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fib_state_e;

    localparam int unsigned LUCAS_T0 = 2;
    localparam int unsigned LUCAS_T1 = 1;

endpackage

// File: rtl/fib_step.sv
// -----------------------------------------------------------------------------
// fib_step
// One combinational step of the recurrence t(j+2) = t(j+1) + t(j), mod 2^N.
// Ports:
//   a, b   in  N : current pair (t(j), t(j+1))
//   a_nxt  out N : t(j+1)
//   b_nxt  out N : t(j+2), wrapped to N bits
//   carry  out 1 : carry out of the N-bit add (the true sum exceeded 2^N - 1)
// -----------------------------------------------------------------------------
module fib_step #(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] a_nxt,
    output logic [N-1:0] b_nxt,
    output logic         carry
);

    assign a_nxt          = b;
    assign {carry, b_nxt} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/fib_seq_gen.sv
// -----------------------------------------------------------------------------
// fib_seq_gen
// Request/response generator returning term t(k) of a Fibonacci-family
// sequence (FIB, LUCAS or user-seeded), modulo 2^N, with a sticky overflow flag.
// Ports:
//   clk        in  1     : rising-edge clock
//   rst        in  1     : asynchronous active-high reset
//   req_valid  in  1     : request present
//   req_ready  out 1     : request can be accepted (registered, IDLE only)
//   req_idx    in  IDX_W : term index k
//   req_mode   in  2     : fib_mode_e seed select (3 behaves as FIB)
//   req_seed0  in  N     : custom t(0), CUSTOM mode only
//   req_seed1  in  N     : custom t(1), CUSTOM mode only
//   rsp_valid  out 1     : result present (registered, DONE only)
//   rsp_ready  in  1     : consumer accepts the result
//   rsp_num    out N     : t(k) mod 2^N
//   rsp_ovf    out 1     : some term t(2)..t(k) exceeded 2^N - 1
// Latency: accept edge E0 -> rsp_valid on edge E(k+1).
// -----------------------------------------------------------------------------
module fib_seq_gen
    import fib_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_idx,
    input  logic [1:0]       req_mode,
    input  logic [N-1:0]     req_seed0,
    input  logic [N-1:0]     req_seed1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_num,
    output logic             rsp_ovf
);

    fib_state_e       state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [N-1:0]     rsp_num_q, rsp_num_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             req_ready_q;
    logic             rsp_valid_q;

    logic [N-1:0]     seed0;
    logic [N-1:0]     seed1;
    logic [N-1:0]     step_a;
    logic [N-1:0]     step_b;
    logic             step_carry;
    logic             accept;

    // req_ready_q is only ever high in IDLE, so it alone qualifies acceptance.
    assign accept = req_valid & req_ready_q;

    // ------------------------------------------------------------------
    // Seed selection; only consulted on the accept edge.
    // ------------------------------------------------------------------
    always_comb begin
        seed0 = '0;
        seed1 = N'(1);
        case (req_mode)
            LUCAS: begin
                seed0 = N'(LUCAS_T0);
                seed1 = N'(LUCAS_T1);
            end
            CUSTOM: begin
                seed0 = req_seed0;
                seed1 = req_seed1;
            end
            default: begin
                // FIB and the reserved encoding.
                seed0 = '0;
                seed1 = N'(1);
            end
        endcase
    end

    fib_step #(
        .N (N)
    ) u_step (
        .a     (a_q),
        .b     (b_q),
        .a_nxt (step_a),
        .b_nxt (step_b),
        .carry (step_carry)
    );

    // ------------------------------------------------------------------
    // Next-state logic.
    // Invariant in CALC after j steps: a = t(j), b = t(j+1), cnt = k - j.
    // The step taken with cnt = c produces t(k - c + 2), so only carries seen
    // while cnt >= 2 belong to terms t(2)..t(k); later ones are discarded.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        rsp_num_d = rsp_num_q;
        rsp_ovf_d = rsp_ovf_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = seed0;
                    b_d     = seed1;
                    cnt_d   = req_idx;
                    ovf_d   = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt_q != '0) begin
                    a_d   = step_a;
                    b_d   = step_b;
                    cnt_d = cnt_q - IDX_W'(1);
                    if (step_carry && (cnt_q > IDX_W'(1))) begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    rsp_num_d = a_q;
                    rsp_ovf_d = ovf_q;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers. The handshake flags are registered
    // decodes of the next state so they are low throughout reset and
    // req_ready only rises on the first clock after release.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            rsp_num_q   <= '0;
            rsp_ovf_q   <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            rsp_num_q   <= rsp_num_d;
            rsp_ovf_q   <= rsp_ovf_d;
            req_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == DONE);
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_num   = rsp_num_q;
    assign rsp_ovf   = rsp_ovf_q;

endmodule
